// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunked multi-cycle adder/subtractor.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk counter width, never narrower than one bit even when NCH == 1.
    function automatic int cnt_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and chunked_adder.
interface chunked_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/chunked_adder_slice.sv
// Combinational CHUNK-wide ripple adder built from per-bit full-adder equations.
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             msb_cin
);
    logic [CHUNK:0] c;

    // NOTE: every always_comb output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout    = c[CHUNK];
    assign msb_cin = c[CHUNK-1];
endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-wide slice per clock, valid/ready on both sides.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    chunked_adder_if.slave  bus
);
    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int CW  = cnt_width(NCH);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CW-1:0]    k_q;

    logic [CHUNK-1:0] slice_a, slice_b, slice_s;
    logic             slice_cout, slice_msb_cin;
    logic             accept, last;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign last    = (k_q == CW'(NCH - 1));
    assign slice_a = a_q[int'(k_q) * CHUNK +: CHUNK];
    assign slice_b = b_q[int'(k_q) * CHUNK +: CHUNK];

    adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a       (slice_a),
        .b       (slice_b),
        .cin     (carry_q),
        .s       (slice_s),
        .cout    (slice_cout),
        .msb_cin (slice_msb_cin)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    a_q     <= bus.a;
                    // Subtract is a + ~b + ~borrow_in.
                    b_q     <= bus.sub ? ~bus.b : bus.b;
                    carry_q <= bus.sub ^ bus.cin;
                    k_q     <= '0;
                end
                RUN: begin
                    sum_q[int'(k_q) * CHUNK +: CHUNK] <= slice_s;
                    carry_q <= slice_cout;
                    k_q     <= k_q + CW'(1);
                    if (last) begin
                        cout_q <= slice_cout;
                        ovf_q  <= slice_cout ^ slice_msb_cin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == RUN);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
